// File: rtl/mul_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined tree multiplier.
// Latency and counter widths are derived here so every file agrees on them.
package mul_pipe_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 32;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // One operand-magnitude stage, one stage per tree level, one output stage.
    function automatic int mul_lat(input int width);
        return clog2(width) + 2;
    endfunction

    function automatic bit width_is_legal(input int width);
        return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
               ((width & (width - 1)) == 0);
    endfunction

endpackage

// File: rtl/mul_tree_level.sv
// One registered level of the partial-product adder tree: N lanes in, N/2 sums out.
// The enable freezes both the sums and the valid bit so a stall holds the whole level.
module mul_tree_level #(
    parameter int N  = 8,
    parameter int SW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic [N*SW-1:0]     in_data,
    output logic                out_valid,
    output logic [(N/2)*SW-1:0] out_data
);

    localparam int M = N / 2;

    logic            valid_q;
    logic            valid_d;
    logic [M*SW-1:0] sum_q;
    logic [M*SW-1:0] sum_d;

    always_comb begin
        valid_d = valid_q;
        sum_d   = sum_q;
        if (en) begin
            valid_d = in_valid;
            for (int j = 0; j < M; j++) begin
                sum_d[j*SW +: SW] = in_data[(2*j)*SW +: SW] + in_data[(2*j+1)*SW +: SW];
            end
        end
    end

    // Only the valid bit needs a reset; stale sums are never observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        sum_q <= sum_d;
    end

    assign out_valid = valid_q;
    assign out_data  = sum_q;

endmodule

// File: rtl/multi_pipe_tree.sv
// Pipelined signed/unsigned multiplier: sign-magnitude operand stage, registered
// binary adder tree over the partial products, then a registered sign-fix stage.
module multi_pipe_tree
    import mul_pipe_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     mul_a,
    input  logic [WIDTH-1:0]                     mul_b,
    input  logic                                 mul_signed,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [2*WIDTH-1:0]                   mul_out,
    output logic [clog2(mul_lat(WIDTH)+1)-1:0]   in_flight
);

    localparam int  LAT      = mul_lat(WIDTH);
    localparam int  LEVELS   = clog2(WIDTH);
    localparam int  PW       = 2 * WIDTH;
    localparam int  IFW      = clog2(LAT + 1);
    localparam bit  WIDTH_OK = width_is_legal(WIDTH);

    if (!WIDTH_OK) begin : g_bad_width
        $error("multi_pipe_tree: illegal WIDTH %0d (power of two, 4..32)", WIDTH);
    end

    // Handshake: a beat moves on in_valid && in_ready, a result on out_valid && out_ready;
    // a held result stalls every stage at once, so in_ready is simply !stall.
    logic stall;
    logic accept;
    logic xfer;
    logic sgn_mode;

    logic             out_valid_q;
    logic             out_valid_d;
    logic [PW-1:0]    mul_out_q;
    logic [PW-1:0]    mul_out_d;
    logic [IFW-1:0]   in_flight_q;
    logic [IFW-1:0]   in_flight_d;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;
    assign sgn_mode = (SIGNED_EN != 0) && mul_signed;

    logic             s1_valid_q;
    logic             s1_valid_d;
    logic             s1_neg_q;
    logic             s1_neg_d;
    logic [WIDTH-1:0] s1_mag_a_q;
    logic [WIDTH-1:0] s1_mag_a_d;
    logic [WIDTH-1:0] s1_mag_b_q;
    logic [WIDTH-1:0] s1_mag_b_d;

    // Negating the most negative value wraps to itself, which read unsigned is the
    // correct magnitude 2^(WIDTH-1).
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_neg_d   = s1_neg_q;
        s1_mag_a_d = s1_mag_a_q;
        s1_mag_b_d = s1_mag_b_q;
        if (!stall) begin
            s1_valid_d = in_valid;
            s1_neg_d   = sgn_mode && (mul_a[WIDTH-1] ^ mul_b[WIDTH-1]);
            s1_mag_a_d = (sgn_mode && mul_a[WIDTH-1]) ? (~mul_a) + WIDTH'(1) : mul_a;
            s1_mag_b_d = (sgn_mode && mul_b[WIDTH-1]) ? (~mul_b) + WIDTH'(1) : mul_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
        s1_neg_q   <= s1_neg_d;
        s1_mag_a_q <= s1_mag_a_d;
        s1_mag_b_q <= s1_mag_b_d;
    end

    logic [WIDTH*PW-1:0] pp_bus;

    always_comb begin
        pp_bus = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s1_mag_b_q[i]) begin
                pp_bus[i*PW +: PW] = PW'(s1_mag_a_q) << i;
            end
        end
    end

    for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
        localparam int NIN = WIDTH >> g;

        logic [NIN*PW-1:0]     lvl_in;
        logic                  lvl_in_valid;
        logic [(NIN/2)*PW-1:0] sum_bus;
        logic                  sum_valid;

        if (g == 0) begin : g_first
            assign lvl_in       = pp_bus;
            assign lvl_in_valid = s1_valid_q;
        end else begin : g_next
            assign lvl_in       = g_lvl[g-1].sum_bus;
            assign lvl_in_valid = g_lvl[g-1].sum_valid;
        end

        mul_tree_level #(
            .N  (NIN),
            .SW (PW)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .en        (!stall),
            .in_valid  (lvl_in_valid),
            .in_data   (lvl_in),
            .out_valid (sum_valid),
            .out_data  (sum_bus)
        );
    end

    logic [PW-1:0] tree_sum;
    logic          tree_valid;

    assign tree_sum   = g_lvl[LEVELS-1].sum_bus;
    assign tree_valid = g_lvl[LEVELS-1].sum_valid;

    // Result sign rides alongside the tree, one bit per level.
    logic [LEVELS-1:0] neg_pipe_q;
    logic [LEVELS-1:0] neg_pipe_d;

    always_comb begin
        neg_pipe_d = neg_pipe_q;
        if (!stall) begin
            neg_pipe_d = {neg_pipe_q[LEVELS-2:0], s1_neg_q};
        end
    end

    always_ff @(posedge clk) begin
        neg_pipe_q <= neg_pipe_d;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        mul_out_d   = mul_out_q;
        if (!stall) begin
            out_valid_d = tree_valid;
            mul_out_d   = neg_pipe_q[LEVELS-1] ? (~tree_sum) + PW'(1) : tree_sum;
        end
    end

    always_comb begin
        in_flight_d = in_flight_q;
        case ({accept, xfer})
            2'b10:   in_flight_d = in_flight_q + IFW'(1);
            2'b01:   in_flight_d = in_flight_q - IFW'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            mul_out_q   <= '0;
            in_flight_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            mul_out_q   <= mul_out_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign out_valid = out_valid_q;
    assign mul_out   = mul_out_q;
    assign in_flight = in_flight_q;

endmodule

// File: tb/tb_multi_pipe_tree.sv
// Directed bench for multi_pipe_tree at WIDTH=8: latency, signed corners, stall,
// reset mid-flight, bubbles, and a SIGNED_EN=0 instance.
module tb_multi_pipe_tree;

    localparam int WIDTH = 8;
    localparam int PW    = 2 * WIDTH;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             in_valid   = 1'b0;
    logic [WIDTH-1:0] mul_a      = '0;
    logic [WIDTH-1:0] mul_b      = '0;
    logic             mul_signed = 1'b0;
    logic             out_ready  = 1'b1;
    logic             in_ready;
    logic             out_valid;
    logic [PW-1:0]    mul_out;
    logic [2:0]       in_flight;

    logic             u_in_valid   = 1'b0;
    logic [WIDTH-1:0] u_mul_a      = '0;
    logic [WIDTH-1:0] u_mul_b      = '0;
    logic             u_mul_signed = 1'b0;
    logic             u_out_ready  = 1'b1;
    logic             u_in_ready;
    logic             u_out_valid;
    logic [PW-1:0]    u_mul_out;
    logic [2:0]       u_in_flight;

    multi_pipe_tree #(.WIDTH(WIDTH), .SIGNED_EN(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_signed (mul_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mul_out    (mul_out),
        .in_flight  (in_flight)
    );

    multi_pipe_tree #(.WIDTH(WIDTH), .SIGNED_EN(0)) u_dut_uns (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (u_in_valid),
        .in_ready   (u_in_ready),
        .mul_a      (u_mul_a),
        .mul_b      (u_mul_b),
        .mul_signed (u_mul_signed),
        .out_valid  (u_out_valid),
        .out_ready  (u_out_ready),
        .mul_out    (u_mul_out),
        .in_flight  (u_in_flight)
    );

    always #5 clk = ~clk;

    int            n_cmp      = 0;
    int            n_err      = 0;
    int            n_xfer     = 0;
    int            stall_left = 0;
    bit            stall_arm  = 1'b0;
    int            max_flight = 0;
    logic [PW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One cycle: apply the stall plan, check the output side, then cross the clock edge.
    task automatic tick(output bit accepted);
        bit in_stall;
        if (stall_arm && out_valid) begin
            stall_arm  = 1'b0;
            stall_left = 4;
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            in_stall = 1'b1;
        end else begin
            out_ready = 1'b1;
            in_stall = 1'b0;
        end
        #1;
        if (in_stall) begin
            check("in_ready_during_stall", in_ready, 1'b0);
            if (exp_q.size() > 0) check("mul_out_held", mul_out, exp_q[0]);
        end
        if (int'(in_flight) > max_flight) max_flight = int'(in_flight);
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) check("unexpected_out_valid", out_valid, 1'b0);
            else check("product", mul_out, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic s,
                              input bit push, input logic [15:0] exp_v);
        bit acc;
        int tries;
        in_valid   = 1'b1;
        mul_a      = a;
        mul_b      = b;
        mul_signed = s;
        if (push) exp_q.push_back(exp_v);
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            tick(acc);
            tries++;
        end
        if (!acc) check("accept_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        repeat (n) tick(acc);
    endtask

    task automatic drain(input int limit);
        bit acc;
        int k;
        in_valid = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < limit) begin
            tick(acc);
            k++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_uns(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [15:0] exp_v, input string tag);
        int cyc;
        u_in_valid   = 1'b1;
        u_mul_a      = a;
        u_mul_b      = b;
        u_mul_signed = s;
        #1;
        check({tag, "_in_ready"}, u_in_ready, 1'b1);
        @(posedge clk);
        #1;
        u_in_valid = 1'b0;
        cyc = 1;
        while (!u_out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, 5);
        check(tag, u_mul_out, exp_v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int x0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_mul_out", mul_out, 16'h0000);
        check("rst_in_flight", in_flight, 3'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1'b1);

        // Unsigned 0xFF*0xFF, latency of five cycles from accept
        in_valid   = 1'b1;
        mul_a      = 8'hFF;
        mul_b      = 8'hFF;
        mul_signed = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency_ff_ff", cyc, 5);
        check("ff_x_ff", mul_out, 16'hFE01);
        check("in_flight_one", in_flight, 3'd1);
        @(posedge clk);
        #1;
        check("out_valid_after_xfer", out_valid, 1'b0);
        check("in_flight_zero", in_flight, 3'd0);

        // Signed corners on back-to-back beats
        drive_beat(8'h80, 8'h80, 1'b1, 1'b1, 16'h4000);
        drive_beat(8'hFF, 8'h7F, 1'b1, 1'b1, 16'hFF81);
        drive_beat(8'hFF, 8'h7F, 1'b0, 1'b1, 16'h7E81);
        drain(20);

        // Ten beats with a four-cycle output stall from the first result
        stall_arm  = 1'b1;
        max_flight = 0;
        drive_beat(8'h03, 8'h05, 1'b0, 1'b1, 16'h000F);
        drive_beat(8'h10, 8'h10, 1'b0, 1'b1, 16'h0100);
        drive_beat(8'h7F, 8'h7F, 1'b1, 1'b1, 16'h3F01);
        drive_beat(8'hFE, 8'h03, 1'b1, 1'b1, 16'hFFFA);
        drive_beat(8'hFE, 8'hFE, 1'b1, 1'b1, 16'h0004);
        drive_beat(8'h80, 8'h01, 1'b1, 1'b1, 16'hFF80);
        drive_beat(8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080);
        drive_beat(8'hC8, 8'h64, 1'b0, 1'b1, 16'h4E20);
        drive_beat(8'h01, 8'hFF, 1'b1, 1'b1, 16'hFFFF);
        drive_beat(8'hAA, 8'h55, 1'b0, 1'b1, 16'h3872);
        drain(40);
        check("in_flight_peak", max_flight, 5);
        check("in_flight_after_stall", in_flight, 3'd0);

        // Reset with three beats in flight: nothing may emerge afterwards
        x0 = n_xfer;
        drive_beat(8'h11, 8'h22, 1'b0, 1'b0, 16'h0000);
        drive_beat(8'h33, 8'h44, 1'b0, 1'b0, 16'h0000);
        drive_beat(8'h55, 8'h66, 1'b1, 1'b0, 16'h0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_mul_out", mul_out, 16'h0000);
        check("midrst_in_flight", in_flight, 3'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        idle(10);
        check("midrst_no_results", n_xfer - x0, 0);

        // Zero operand with bubbles in between
        x0 = n_xfer;
        drive_beat(8'h00, 8'hAB, 1'b0, 1'b1, 16'h0000);
        idle(1);
        drive_beat(8'h00, 8'hAB, 1'b1, 1'b1, 16'h0000);
        idle(2);
        drive_beat(8'h00, 8'hAB, 1'b0, 1'b1, 16'h0000);
        drain(20);
        check("bubble_result_count", n_xfer - x0, 3);

        // SIGNED_EN=0 instance ignores mul_signed
        run_uns(8'h80, 8'h02, 1'b1, 16'h0100, "uns_80_x_02");
        run_uns(8'hFF, 8'hFF, 1'b1, 16'hFE01, "uns_ff_x_ff");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
